// File: rtl/pc_redirect_unit.sv
// IF-stage program counter with fixed-priority redirects and a
// stall-time pending slot so redirects seen while frozen are not lost.
module pc_redirect_unit #(
  parameter int WIDTH      = 32,
  parameter int NSRC       = 4,
  parameter int RESET_PC   = 0,
  parameter int ALIGN_BITS = 2,
  parameter int SELW       = $clog2(NSRC+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush_pending,
  input  logic [NSRC-1:0]       src_valid,
  input  logic [NSRC*WIDTH-1:0] src_pc,
  output logic [WIDTH-1:0]      pc_out,
  output logic [SELW-1:0]       pc_sel,
  output logic                  redirect_taken,
  output logic                  pending_valid,
  output logic                  misalign_err
);

  localparam logic [SELW-1:0]  SEQ  = SELW'(NSRC);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(1) << ALIGN_BITS;
  localparam logic [WIDTH-1:0] LOWM = STEP - WIDTH'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             rt_q, rt_d;
  logic             me_q, me_d;
  logic             pv_q, pv_d;
  logic [SELW-1:0]  pidx_q, pidx_d;
  logic [WIDTH-1:0] ptgt_q, ptgt_d;

  logic             live_vld;
  logic [SELW-1:0]  live_idx;
  logic [WIDTH-1:0] live_tgt;
  logic             use_pend;
  logic             live_wins;
  logic [WIDTH-1:0] tgt;

  // Scan downward so the lowest valid index is the last to assign.
  always_comb begin
    live_vld = 1'b0;
    live_idx = SEQ;
    live_tgt = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        live_vld = 1'b1;
        live_idx = SELW'(i);
        live_tgt = src_pc[i*WIDTH +: WIDTH];
      end
    end
  end

  assign use_pend  = pv_q && !flush_pending;
  assign live_wins = live_vld && (!use_pend || live_idx <= pidx_q);

  always_comb begin
    pc_d   = pc_q;
    sel_d  = sel_q;
    rt_d   = 1'b0;
    me_d   = 1'b0;
    pv_d   = pv_q;
    pidx_d = pidx_q;
    ptgt_d = ptgt_q;
    tgt    = '0;
    if (enable) begin
      pv_d   = 1'b0;
      pidx_d = SEQ;
      ptgt_d = '0;
      if (live_wins) begin
        tgt   = live_tgt;
        sel_d = live_idx;
        rt_d  = 1'b1;
      end else if (use_pend) begin
        tgt   = ptgt_q;
        sel_d = pidx_q;
        rt_d  = 1'b1;
      end
      if (rt_d) begin
        pc_d = tgt & ~LOWM;
        me_d = |(tgt & LOWM);
      end else begin
        pc_d  = pc_q + STEP;
        sel_d = SEQ;
      end
    end else if (flush_pending) begin
      pv_d   = 1'b0;
      pidx_d = SEQ;
      ptgt_d = '0;
    end else if (live_vld && (!pv_q || live_idx <= pidx_q)) begin
      pv_d   = 1'b1;
      pidx_d = live_idx;
      ptgt_d = live_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= WIDTH'(RESET_PC);
      sel_q  <= SEQ;
      rt_q   <= 1'b0;
      me_q   <= 1'b0;
      pv_q   <= 1'b0;
      pidx_q <= SEQ;
      ptgt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      sel_q  <= sel_d;
      rt_q   <= rt_d;
      me_q   <= me_d;
      pv_q   <= pv_d;
      pidx_q <= pidx_d;
      ptgt_q <= ptgt_d;
    end
  end

  assign pc_out         = pc_q;
  assign pc_sel         = sel_q;
  assign redirect_taken = rt_q;
  assign pending_valid  = pv_q;
  assign misalign_err   = me_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit; expected outputs are queued
// at drive time and popped after each rising edge.
module tb_pc_redirect_unit;

  localparam int W = 32;
  localparam int N = 4;
  localparam int SW = $clog2(N+1);

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            flush_pending;
  logic [N-1:0]    src_valid;
  logic [N*W-1:0]  src_pc;
  logic [W-1:0]    pc_out;
  logic [SW-1:0]   pc_sel;
  logic            redirect_taken;
  logic            pending_valid;
  logic            misalign_err;

  typedef struct {
    logic [W-1:0]  pc;
    logic [SW-1:0] sel;
    logic          rt;
    logic          pv;
    logic          me;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  pc_redirect_unit dut (
    .clk(clk), .reset(reset), .enable(enable),
    .flush_pending(flush_pending), .src_valid(src_valid),
    .src_pc(src_pc), .pc_out(pc_out), .pc_sel(pc_sel),
    .redirect_taken(redirect_taken),
    .pending_valid(pending_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en,
                      input logic fl, input logic [N-1:0] sv,
                      input logic [W-1:0] t0, input logic [W-1:0] t1,
                      input logic [W-1:0] t2, input logic [W-1:0] t3,
                      input logic [W-1:0] epc, input int esel,
                      input logic ert, input logic epv,
                      input logic eme, input string tag);
    exp_t e;
    exp_t g;
    reset = rst;
    enable = en;
    flush_pending = fl;
    src_valid = sv;
    src_pc = {t3, t2, t1, t0};
    e.pc = epc;
    e.sel = SW'(esel);
    e.rt = ert;
    e.pv = epv;
    e.me = eme;
    q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (q.size() > 0) begin
      g = q.pop_front();
      chk({tag, "_pc"}, pc_out, g.pc);
      chk({tag, "_sel"}, W'(pc_sel), W'(g.sel));
      chk({tag, "_rt"}, W'(redirect_taken), W'(g.rt));
      chk({tag, "_pv"}, W'(pending_valid), W'(g.pv));
      chk({tag, "_me"}, W'(misalign_err), W'(g.me));
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    flush_pending = 1'b0;
    src_valid = '0;
    src_pc = '0;
    #1;
    // rst en fl valid  t0 t1 t2 t3 | pc sel rt pv me
    step(1,0,0,4'b0000, 0,0,0,0, 32'h0, 4,0,0,0, "reset");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h4, 4,0,0,0, "seq1");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h8, 4,0,0,0, "seq2");
    step(0,1,0,4'b0000, 0,0,0,0, 32'hC, 4,0,0,0, "seq3");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h10, 4,0,0,0, "seq4");
    step(0,1,0,4'b1010, 0,32'h100,0,32'h200,
         32'h100, 1,1,0,0, "prio");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h104, 4,0,0,0, "after");
    // stall capture, hold, apply
    step(0,0,0,4'b0100, 0,0,32'h300,0, 32'h104, 4,0,1,0, "cap");
    step(0,0,0,4'b0000, 0,0,0,0, 32'h104, 4,0,1,0, "hold1");
    step(0,0,0,4'b0000, 0,0,0,0, 32'h104, 4,0,1,0, "hold2");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h300, 2,1,0,0, "apply");
    // lower-priority arrival does not replace
    step(0,0,0,4'b0100, 0,0,32'h300,0, 32'h300, 2,0,1,0, "cap2");
    step(0,0,0,4'b1000, 0,0,0,32'h400, 32'h300, 2,0,1,0, "lowpri");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h300, 2,1,0,0, "keep2");
    // higher-priority arrival replaces
    step(0,0,0,4'b0100, 0,0,32'h300,0, 32'h300, 2,0,1,0, "cap3");
    step(0,0,0,4'b1000, 0,0,0,32'h400, 32'h300, 2,0,1,0, "low3");
    step(0,0,0,4'b0001, 32'h500,0,0,0, 32'h300, 2,0,1,0, "repl");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h500, 0,1,0,0, "applyr");
    // pending beats lower-priority live request
    step(0,0,0,4'b0010, 0,32'h700,0,0, 32'h500, 0,0,1,0, "cap4");
    step(0,1,0,4'b0100, 0,0,32'h800,0, 32'h700, 1,1,0,0, "pendwin");
    // equal index: live wins
    step(0,0,0,4'b0010, 0,32'h700,0,0, 32'h700, 1,0,1,0, "cap5");
    step(0,1,0,4'b0010, 0,32'h900,0,0, 32'h900, 1,1,0,0, "livewin");
    // flush while stalled
    step(0,0,0,4'b0010, 0,32'h600,0,0, 32'h900, 1,0,1,0, "cap6");
    step(0,0,1,4'b0000, 0,0,0,0, 32'h900, 1,0,0,0, "flush");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h904, 4,0,0,0, "postfl");
    // flush overrides capture
    step(0,0,1,4'b0010, 0,32'h600,0,0, 32'h904, 4,0,0,0, "flcap");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h908, 4,0,0,0, "flcap2");
    // flush with enable ignores pending, honours live
    step(0,0,0,4'b0001, 32'hA00,0,0,0, 32'h908, 4,0,1,0, "cap7");
    step(0,1,1,4'b0100, 0,0,32'hB00,0, 32'hB00, 2,1,0,0, "flen");
    step(0,0,0,4'b0001, 32'hA00,0,0,0, 32'hB00, 2,0,1,0, "cap8");
    step(0,1,1,4'b0000, 0,0,0,0, 32'hB04, 4,0,0,0, "flseq");
    // misaligned target
    step(0,1,0,4'b0001, 32'h103,0,0,0, 32'h100, 0,1,0,1, "mis");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h104, 4,0,0,0, "misoff");
    // misaligned pending target
    step(0,0,0,4'b0100, 0,0,32'h302,0, 32'h104, 4,0,1,0, "cap9");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h300, 2,1,0,1, "mispend");
    // wrap
    step(0,1,0,4'b0001, 32'hFFFFFFFC,0,0,0,
         32'hFFFFFFFC, 0,1,0,0, "top");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h0, 4,0,0,0, "wrap");
    // reset mid-stall with pending held
    step(0,1,0,4'b0000, 0,0,0,0, 32'h4, 4,0,0,0, "pre");
    step(0,0,0,4'b0010, 0,32'h600,0,0, 32'h4, 4,0,1,0, "cap10");
    step(1,0,0,4'b0000, 0,0,0,0, 32'h0, 4,0,0,0, "rstmid");
    step(0,1,0,4'b0000, 0,0,0,0, 32'h4, 4,0,0,0, "postrst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
